mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction port 0 (read-only) and data port 1 (read/write)
// share one memory; read responses are routed back through a fixed-latency tag pipeline.
module mem_arbiter #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DATA_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o,
  output logic        mem_data_en,
  output logic        mem_write_en,

  output logic [15:0] conflict_cnt
);

  // last_q: 1 means port 1 was granted most recently
  logic               last_q, last_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_port_q, tag_port_d;
  logic [15:0]        conflict_cnt_q, conflict_cnt_d;
  logic               gnt0, gnt1;
  logic               rd_issue;

  // Grants are gated by reset so nothing leaks onto the bus while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (p0_req && p1_req) begin
        if ((DATA_PRIO == 1) || !last_q) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  always_comb begin
    mem_addr     = 32'h0;
    mem_data_i   = 32'h0;
    mem_data_en  = 1'b0;
    mem_write_en = 1'b0;
    if (gnt0) begin
      mem_addr    = p0_addr;
      mem_data_en = 1'b1;
    end else if (gnt1) begin
      mem_addr     = p1_addr;
      mem_data_i   = p1_wdata;
      mem_data_en  = 1'b1;
      mem_write_en = p1_we;
    end
  end

  assign rd_issue = gnt0 | (gnt1 & ~p1_we);

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    tag_vld_d     = '0;
    tag_port_d    = '0;
    tag_vld_d[0]  = rd_issue;
    tag_port_d[0] = gnt1;
    for (int i = 1; i < int'(LATENCY); i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_port_d[i] = tag_port_q[i-1];
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (p0_req && p1_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q         <= 1'b1;
      tag_vld_q      <= '0;
      tag_port_q     <= '0;
      conflict_cnt_q <= 16'h0;
    end else begin
      last_q         <= last_d;
      tag_vld_q      <= tag_vld_d;
      tag_port_q     <= tag_port_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign p0_rvalid    = tag_vld_q[LATENCY-1] & ~tag_port_q[LATENCY-1];
  assign p1_rvalid    = tag_vld_q[LATENCY-1] &  tag_port_q[LATENCY-1];
  assign p0_rdata     = p0_rvalid ? mem_data_o : 32'h0;
  assign p1_rdata     = p1_rvalid ? mem_data_o : 32'h0;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiter configurations share one stimulus stream;
// a = LATENCY 1 round-robin, b = LATENCY 3 round-robin, c = LATENCY 2 data priority.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req, p1_we;
  logic [31:0] p0_addr, p1_addr, p1_wdata, mem_rd;

  logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid, a_en, a_we;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_addr, a_wd;
  logic [15:0] a_cnt;
  logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid, b_en, b_we;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_addr, b_wd;
  logic [15:0] b_cnt;
  logic        c_p0_gnt, c_p0_rvalid, c_p1_gnt, c_p1_rvalid, c_en, c_we;
  logic [31:0] c_p0_rdata, c_p1_rdata, c_addr, c_wd;
  logic [15:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(1), .DATA_PRIO(0)) u_a (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid),
    .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .mem_addr(a_addr), .mem_data_i(a_wd), .mem_data_o(mem_rd), .mem_data_en(a_en),
    .mem_write_en(a_we), .conflict_cnt(a_cnt)
  );

  mem_arbiter #(.LATENCY(3), .DATA_PRIO(0)) u_b (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid),
    .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_addr(b_addr), .mem_data_i(b_wd), .mem_data_o(mem_rd), .mem_data_en(b_en),
    .mem_write_en(b_we), .conflict_cnt(b_cnt)
  );

  mem_arbiter #(.LATENCY(2), .DATA_PRIO(1)) u_c (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(c_p0_gnt), .p0_rvalid(c_p0_rvalid),
    .p0_rdata(c_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_gnt(c_p1_gnt), .p1_rvalid(c_p1_rvalid), .p1_rdata(c_p1_rdata),
    .mem_addr(c_addr), .mem_data_i(c_wd), .mem_data_o(mem_rd), .mem_data_en(c_en),
    .mem_write_en(c_we), .conflict_cnt(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req   = 1'b0;
    p1_req   = 1'b0;
    p1_we    = 1'b0;
    p0_addr  = 32'h0;
    p1_addr  = 32'h0;
    p1_wdata = 32'h0;
    mem_rd   = 32'h0;
  endtask

  // Next cycle: inputs are changed 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    // Requests during reset must produce nothing.
    p0_req  = 1'b1;
    p0_addr = 32'h44;
    p1_req  = 1'b1;
    cyc();
    chk("rst_p0_gnt", a_p0_gnt, 0);
    chk("rst_p1_gnt", a_p1_gnt, 0);
    chk("rst_mem_en", a_en, 0);
    chk("rst_mem_addr", a_addr, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_rvalid", a_p0_rvalid, 0);

    // Single p0 read, LATENCY 1.
    do_reset();
    p0_req  = 1'b1;
    p0_addr = 32'h100;
    #1;
    chk("rd_p0_gnt", a_p0_gnt, 1);
    chk("rd_mem_en", a_en, 1);
    chk("rd_mem_addr", a_addr, 32'h100);
    chk("rd_mem_we", a_we, 0);
    chk("rd_p1_gnt", a_p1_gnt, 0);
    cyc();
    p0_req = 1'b0;
    mem_rd = 32'hCAFE0001;
    #1;
    chk("rd_p0_rvalid", a_p0_rvalid, 1);
    chk("rd_p0_rdata", a_p0_rdata, 32'hCAFE0001);
    chk("rd_p1_rvalid", a_p1_rvalid, 0);
    chk("rd_p1_rdata", a_p1_rdata, 0);
    chk("idle_mem_en", a_en, 0);
    chk("idle_mem_addr", a_addr, 0);
    cyc();
    chk("rd_p0_rvalid_once", a_p0_rvalid, 0);
    chk("rd_p0_rdata_zero", a_p0_rdata, 0);

    // Continuous conflict for 6 cycles: round-robin 0,1,0,1,0,1; priority always 1.
    do_reset();
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    p0_addr = 32'h10;
    p1_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_p0_gnt", a_p0_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_p1_gnt", a_p1_gnt, (i % 2 == 1) ? 1 : 0);
      chk("rr_addr", a_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk("prio_p1_gnt", c_p1_gnt, 1);
      chk("prio_p0_gnt", c_p0_gnt, 0);
      cyc();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    #1;
    chk("rr_cnt", a_cnt, 6);
    chk("prio_cnt", c_cnt, 6);

    // p1 write concurrent with p0 read after reset.
    do_reset();
    p0_req   = 1'b1;
    p0_addr  = 32'h300;
    p1_req   = 1'b1;
    p1_we    = 1'b1;
    p1_addr  = 32'h200;
    p1_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_first_p0", a_p0_gnt, 1);
    chk("wr_first_we", a_we, 0);
    chk("wr_first_addr", a_addr, 32'h300);
    cyc();
    p0_req = 1'b0;
    mem_rd = 32'h0000BEEF;
    #1;
    chk("wr_p1_gnt", a_p1_gnt, 1);
    chk("wr_we", a_we, 1);
    chk("wr_data", a_wd, 32'hDEADBEEF);
    chk("wr_addr", a_addr, 32'h200);
    chk("wr_p0_rvalid", a_p0_rvalid, 1);
    chk("wr_p0_rdata", a_p0_rdata, 32'h0000BEEF);
    cyc();
    p1_req = 1'b0;
    p1_we  = 1'b0;
    #1;
    chk("wr_no_p1_rvalid", a_p1_rvalid, 0);
    chk("wr_no_p0_rvalid", a_p0_rvalid, 0);

    // LATENCY 3: grants p0,p1,p0 then responses in order.
    do_reset();
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    p0_addr = 32'hA0;
    p1_addr = 32'hB0;
    #1;
    chk("l3_g0_p0", b_p0_gnt, 1);
    cyc();
    chk("l3_g1_p1", b_p1_gnt, 1);
    cyc();
    p1_req = 1'b0;
    #1;
    chk("l3_g2_p0", b_p0_gnt, 1);
    chk("l3_early", b_p0_rvalid | b_p1_rvalid, 0);
    cyc();
    p0_req = 1'b0;
    mem_rd = 32'h11110000;
    #1;
    chk("l3_r0_p0", b_p0_rvalid, 1);
    chk("l3_r0_p1", b_p1_rvalid, 0);
    chk("l3_r0_data", b_p0_rdata, 32'h11110000);
    cyc();
    mem_rd = 32'h22220000;
    #1;
    chk("l3_r1_p1", b_p1_rvalid, 1);
    chk("l3_r1_p0", b_p0_rvalid, 0);
    chk("l3_r1_data", b_p1_rdata, 32'h22220000);
    chk("l3_r1_p0data", b_p0_rdata, 0);
    cyc();
    mem_rd = 32'h33330000;
    #1;
    chk("l3_r2_p0", b_p0_rvalid, 1);
    chk("l3_r2_data", b_p0_rdata, 32'h33330000);
    cyc();
    chk("l3_done", b_p0_rvalid | b_p1_rvalid, 0);

    // LATENCY 2: reset one cycle after a read grant discards the response.
    do_reset();
    p0_req  = 1'b1;
    p0_addr = 32'hC0;
    #1;
    chk("l2_gnt", c_p0_gnt, 1);
    cyc();
    p0_req = 1'b0;
    reset  = 1'b0;
    #1;
    chk("l2_rst_rvalid", c_p0_rvalid, 0);
    cyc();
    reset = 1'b1;
    #1;
    chk("l2_after_rvalid", c_p0_rvalid, 0);
    chk("l2_after_cnt", c_cnt, 0);
    cyc();
    chk("l2_after_rvalid2", c_p0_rvalid | c_p1_rvalid, 0);

    // Saturation of the conflict counter.
    do_reset();
    p0_req = 1'b1;
    p1_req = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", a_cnt, 16'hFFFE);
    cyc();
    chk("sat_ffff", a_cnt, 16'hFFFF);
    repeat (4400) @(posedge clk);
    #1;
    chk("sat_hold", a_cnt, 16'hFFFF);
    chk("sat_hold_c", c_cnt, 16'hFFFF);
    p0_req = 1'b0;
    p1_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
